// File: rtl/decode_pkg.sv
// Shared ISA constants for the SimpleRISC decode stage: opcodes, immediate
// modifiers, field positions and the branch-offset helper.
package decode_pkg;

   typedef enum logic [4:0] {
      OP_ADD = 5'd0,  OP_SUB = 5'd1,  OP_MUL  = 5'd2,  OP_DIV = 5'd3,
      OP_MOD = 5'd4,  OP_CMP = 5'd5,  OP_AND  = 5'd6,  OP_OR  = 5'd7,
      OP_NOT = 5'd8,  OP_MOV = 5'd9,  OP_LSL  = 5'd10, OP_LSR = 5'd11,
      OP_ASR = 5'd12, OP_NOP = 5'd13, OP_LD   = 5'd14, OP_ST  = 5'd15,
      OP_BEQ = 5'd16, OP_BGT = 5'd17, OP_B    = 5'd18, OP_CALL = 5'd19,
      OP_RET = 5'd20
   } opcode_e;

   typedef enum logic [1:0] {
      MOD_SIGNED   = 2'b00,
      MOD_UNSIGNED = 2'b01,
      MOD_HIGH     = 2'b10
   } mod_e;

   localparam int OPCODE_LSB  = 27;
   localparam int IMM_BIT     = 26;
   localparam int RD_LSB      = 22;
   localparam int RS1_LSB     = 18;
   localparam int RS2_LSB     = 14;
   localparam int REG_W       = 4;
   localparam int IMM_FIELD_W = 18;
   localparam int OFFSET_W    = 27;

   localparam logic [REG_W-1:0] RA_REG = 4'd15;

   // Word offset to byte offset: sign-extend, scale by 4, drop carry-out bits.
   function automatic logic [31:0] branch_offset(input logic [OFFSET_W-1:0] off);
      return {{3{off[OFFSET_W-1]}}, off, 2'b00};
   endfunction

endpackage

// File: rtl/decode_if.sv
// Fetch-to-decode bus: instruction/PC in, registered decoded fields out.
interface decode_if;
   import decode_pkg::*;

   logic [31:0]      inst;
   logic [31:0]      pc;
   logic [4:0]       opcode;
   logic             immediate_bit;
   logic [31:0]      branch_tgt;
   logic [REG_W-1:0] rd;
   logic [REG_W-1:0] rs1;
   logic [REG_W-1:0] rs2;
   logic [31:0]      immx;

   modport master (
      output inst, pc,
      input  opcode, immediate_bit, branch_tgt, rd, rs1, rs2, immx
   );

   modport slave (
      input  inst, pc,
      output opcode, immediate_bit, branch_tgt, rd, rs1, rs2, immx
   );
endinterface

// File: rtl/decode_imm_extend.sv
// Combinational immediate extender: modifier inst[17:16] picks how inst[15:0]
// widens to 32 bits; the unused modifier 2'b11 falls back to sign extension.
module decode_imm_extend
   import decode_pkg::*;
(
   input  logic [IMM_FIELD_W-1:0] imm_field,
   output logic [31:0]            immx
);

   logic [15:0] imm16;
   assign imm16 = imm_field[15:0];

   // NOTE: a default assignment before the case keeps every path driven, so no latch.
   always_comb begin
      immx = {{16{imm16[15]}}, imm16};
      case (imm_field[17:16])
         MOD_UNSIGNED: immx = {16'h0, imm16};
         MOD_HIGH:     immx = {imm16, 16'h0};
         default:      immx = {{16{imm16[15]}}, imm16};
      endcase
   end

endmodule

// File: rtl/decode.sv
// SimpleRISC decode stage: splits the instruction into fields, extends the
// immediate and forms the branch target; all outputs registered one cycle later.
module decode
   import decode_pkg::*;
(
   input  logic      clk,
   input  logic      reset,
   decode_if.slave   bus
);

   logic [4:0]       opcode_next;
   logic [REG_W-1:0] rd_next;
   logic [REG_W-1:0] rs1_next;
   logic [REG_W-1:0] rs2_next;
   logic [31:0]      immx_next;
   logic [31:0]      tgt_next;

   assign opcode_next = bus.inst[OPCODE_LSB +: 5];
   assign rd_next     = bus.inst[RD_LSB +: REG_W];
   assign tgt_next    = bus.pc + branch_offset(bus.inst[OFFSET_W-1:0]);

   // ret implicitly reads ra; st carries its data register in the rd slot.
   always_comb begin
      rs1_next = bus.inst[RS1_LSB +: REG_W];
      rs2_next = bus.inst[RS2_LSB +: REG_W];
      if (opcode_next == OP_RET) rs1_next = RA_REG;
      if (opcode_next == OP_ST)  rs2_next = rd_next;
   end

   decode_imm_extend u_imm_extend (
      .imm_field (bus.inst[IMM_FIELD_W-1:0]),
      .immx      (immx_next)
   );

   // NOTE: non-blocking assignments for state so every register samples pre-edge values.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.opcode        <= '0;
         bus.immediate_bit <= 1'b0;
         bus.branch_tgt    <= '0;
         bus.rd            <= '0;
         bus.rs1           <= '0;
         bus.rs2           <= '0;
         bus.immx          <= '0;
      end else begin
         bus.opcode        <= opcode_next;
         bus.immediate_bit <= bus.inst[IMM_BIT];
         bus.branch_tgt    <= tgt_next;
         bus.rd            <= rd_next;
         bus.rs1           <= rs1_next;
         bus.rs2           <= rs2_next;
         bus.immx          <= immx_next;
      end
   end

endmodule

// File: tb/tb_decode.sv
// Self-checking bench for decode: directed literal cases plus randomized
// instructions compared every cycle against an arithmetic reference model.
module tb_decode;

   typedef struct {
      logic [4:0]  opcode;
      logic        immb;
      logic [3:0]  rd;
      logic [3:0]  rs1;
      logic [3:0]  rs2;
      logic [31:0] immx;
      logic [31:0] tgt;
   } exp_t;

   logic clk = 1'b0;
   logic reset;
   int   total = 0;
   int   bad = 0;
   bit   cmp_en = 0;
   exp_t exp_q;

   decode_if bus ();

   decode dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Reference model straight from the ISA rules, using integer arithmetic.
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] p);
      exp_t        m;
      int unsigned op;
      int unsigned lo;
      int unsigned md;
      longint      off;
      op       = i >> 27;
      m.opcode = 5'(op);
      m.immb   = 1'((i >> 26) & 1);
      m.rd     = 4'((i >> 22) & 15);
      m.rs1    = (op == 20) ? 4'd15 : 4'((i >> 18) & 15);
      m.rs2    = (op == 15) ? m.rd : 4'((i >> 14) & 15);
      lo       = i & 32'hFFFF;
      md       = (i >> 16) & 3;
      if (md == 1)           m.immx = lo;
      else if (md == 2)      m.immx = lo * 65536;
      else if (lo >= 32768)  m.immx = 32'(longint'(lo) - 65536);
      else                   m.immx = lo;
      off = longint'(i & 32'h07FF_FFFF);
      if (off >= 64'd67108864) off = off - 134217728;
      m.tgt = 32'(longint'(p) + off * 4);
      return m;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Expected outputs: cleared asynchronously, else the model of the edge's inputs.
   always @(posedge clk or posedge reset) begin
      if (reset) exp_q <= '{default: '0};
      else       exp_q <= model(bus.inst, bus.pc);
   end

   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_opcode", 32'(bus.opcode),        32'(exp_q.opcode));
         check("cyc_immb",   32'(bus.immediate_bit), 32'(exp_q.immb));
         check("cyc_rd",     32'(bus.rd),            32'(exp_q.rd));
         check("cyc_rs1",    32'(bus.rs1),           32'(exp_q.rs1));
         check("cyc_rs2",    32'(bus.rs2),           32'(exp_q.rs2));
         check("cyc_immx",   bus.immx,               exp_q.immx);
         check("cyc_tgt",    bus.branch_tgt,         exp_q.tgt);
      end
   end

   task automatic drive(input logic [31:0] i, input logic [31:0] p);
      @(posedge clk);
      #1;
      bus.inst = i;
      bus.pc   = p;
   endtask

   task automatic settle();
      @(posedge clk);
      #1;
   endtask

   logic [31:0] mod_inst [4] = '{32'h4D40FFFF, 32'h4D41FFFF, 32'h4D42FFFF, 32'h4D43FFFF};
   logic [31:0] mod_immx [4] = '{32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFF0000, 32'hFFFFFFFF};

   initial begin
      exp_t m;
      logic [31:0] r;
      reset    = 1'b1;
      bus.inst = '0;
      bus.pc   = '0;
      repeat (2) @(posedge clk);
      #1;
      cmp_en = 1;
      check("rst_opcode", 32'(bus.opcode), 32'd0);
      check("rst_tgt",    bus.branch_tgt,  32'd0);
      reset = 1'b0;

      // Model pinned against hand-computed values.
      m = model(32'hf23b78da, 32'h0);
      check("model_t1_tgt",  m.tgt,  32'h08ede368);
      check("model_t1_immx", m.immx, 32'h000078da);
      m = model(32'h97FFFFFF, 32'h0);
      check("model_wrap",    m.tgt,  32'hFFFFFFFC);
      m = model(32'h7CC80004, 32'h0);
      check("model_st_rs2",  32'(m.rs2), 32'd3);

      // Async reset mid-operation, then first decode after release.
      drive(32'hf23b78da, 32'h0);
      settle();
      check("pre_rst_opcode", 32'(bus.opcode), 32'd30);
      #1;
      reset = 1'b1;
      #1;
      check("async_opcode", 32'(bus.opcode), 32'd0);
      check("async_rd",     32'(bus.rd),     32'd0);
      check("async_immx",   bus.immx,        32'd0);
      check("async_tgt",    bus.branch_tgt,  32'd0);
      settle();
      reset = 1'b0;
      settle();
      check("t1_opcode", 32'(bus.opcode),        32'd30);
      check("t1_immb",   32'(bus.immediate_bit), 32'd0);
      check("t1_rd",     32'(bus.rd),            32'd8);
      check("t1_rs1",    32'(bus.rs1),           32'd14);
      check("t1_rs2",    32'(bus.rs2),           32'd13);
      check("t1_immx",   bus.immx,               32'h000078da);
      check("t1_tgt",    bus.branch_tgt,         32'h08ede368);

      // add r1,r2,r3: outputs hold until the next edge.
      bus.inst = 32'h0048C000;
      #1;
      check("t2_hold_opcode", 32'(bus.opcode), 32'd30);
      settle();
      check("t2_opcode", 32'(bus.opcode),        32'd0);
      check("t2_immb",   32'(bus.immediate_bit), 32'd0);
      check("t2_rd",     32'(bus.rd),            32'd1);
      check("t2_rs1",    32'(bus.rs1),           32'd2);
      check("t2_rs2",    32'(bus.rs2),           32'd3);

      for (int k = 0; k < 4; k++) begin
         bus.inst = mod_inst[k];
         settle();
         check($sformatf("t3_immx_%0d", k), bus.immx, mod_immx[k]);
         check($sformatf("t3_rd_%0d", k),   32'(bus.rd), 32'd5);
         check($sformatf("t3_immb_%0d", k), 32'(bus.immediate_bit), 32'd1);
      end

      bus.inst = 32'h97FFFFFF;
      bus.pc   = 32'h100;
      settle();
      check("t4_opcode", 32'(bus.opcode), 32'd18);
      check("t4_tgt",    bus.branch_tgt,  32'h000000FC);
      bus.pc = 32'h0;
      settle();
      check("t4_wrap",   bus.branch_tgt,  32'hFFFFFFFC);

      bus.inst = 32'h7CC80004;
      settle();
      check("t5_opcode", 32'(bus.opcode),        32'd15);
      check("t5_rd",     32'(bus.rd),            32'd3);
      check("t5_rs1",    32'(bus.rs1),           32'd2);
      check("t5_rs2",    32'(bus.rs2),           32'd3);
      check("t5_immx",   bus.immx,               32'd4);
      check("t5_immb",   32'(bus.immediate_bit), 32'd1);

      bus.inst = 32'hA0000000;
      settle();
      check("t6_opcode", 32'(bus.opcode), 32'd20);
      check("t6_rs1",    32'(bus.rs1),    32'd15);

      // Back-to-back random instructions; opcodes with special rules are biased in.
      for (int n = 0; n < 400; n++) begin
         r = $urandom;
         case ($urandom_range(0, 7))
            0: r[31:27] = 5'd15;
            1: r[31:27] = 5'd20;
            2: r[31:27] = 5'($urandom_range(21, 31));
            default: ;
         endcase
         bus.inst = r;
         bus.pc   = $urandom;
         if (n == 200) begin
            #1;
            reset = 1'b1;
         end
         if (n == 203) reset = 1'b0;
         settle();
      end

      cmp_en = 0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
